// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters followed by one registered output stage.
// Optional frame counter output enabled by defining VGA_TIMING_FRAMECNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clkP,
  input  logic          rst,
  input  logic          pix_ce,
  output logic [HW-1:0] pixelX,
  output logic [VW-1:0] pixelY,
  output logic          sincH,
  output logic          sincV,
  output logic          video,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic H_ON = 1'(H_POL);
  localparam logic V_ON = 1'(V_POL);

  logic [HW-1:0] hCntP0;
  logic [VW-1:0] vCntP0;
  logic          lineWrapP0;
  logic          frameWrapP0;

  logic hLast;
  logic vLast;
  logic hVisible;
  logic vVisible;
  logic hSyncWin;
  logic vSyncWin;

  always_comb begin
    hLast    = (hCntP0 == H_LAST);
    vLast    = (vCntP0 == V_LAST);
    hVisible = (hCntP0 < H_ACT_END);
    vVisible = (vCntP0 < V_ACT_END);
    hSyncWin = (hCntP0 >= H_SYNC_BEG) && (hCntP0 < H_SYNC_END);
    vSyncWin = (vCntP0 >= V_SYNC_BEG) && (vCntP0 < V_SYNC_END);
  end

  // Stage p0: position counters; wrap flags live for exactly one clk after the wrapping edge.
  always_ff @(posedge clkP) begin
    if (rst) begin
      hCntP0      <= '0;
      vCntP0      <= '0;
      lineWrapP0  <= 1'b0;
      frameWrapP0 <= 1'b0;
    end else begin
      lineWrapP0  <= pix_ce && hLast;
      frameWrapP0 <= pix_ce && hLast && vLast;
      if (pix_ce) begin
        if (hLast) begin
          hCntP0 <= '0;
          vCntP0 <= vLast ? '0 : vCntP0 + VW'(1);
        end else begin
          hCntP0 <= hCntP0 + HW'(1);
        end
      end
    end
  end

  // Stage p1: registered outputs, all describing the same counter snapshot.
  always_ff @(posedge clkP) begin
    if (rst) begin
      pixelX      <= '0;
      pixelY      <= '0;
      sincH       <= ~H_ON;
      sincV       <= ~V_ON;
      video       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixelX      <= hCntP0;
      pixelY      <= vCntP0;
      sincH       <= hSyncWin ? H_ON : ~H_ON;
      sincV       <= vSyncWin ? V_ON : ~V_ON;
      video       <= hVisible && vVisible;
      line_start  <= lineWrapP0;
      frame_start <= frameWrapP0;
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  always_ff @(posedge clkP) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (frameWrapP0) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a 16x8 raster; expected outputs are queued per step and popped after the edge.
// Frame counter checks are included when VGA_TIMING_FRAMECNT_EN is defined.
module tb_vga_timing_gen;

  logic       clkP = 1'b0;
  logic       rst = 1'b1;
  logic       pix_ce = 1'b1;
  logic [4:0] pixelX;
  logic [3:0] pixelY;
  logic       sincH;
  logic       sincV;
  logic       video;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .HW(5), .VW(4)
  ) dut (
    .clkP(clkP),
    .rst(rst),
    .pix_ce(pix_ce),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .sincH(sincH),
    .sincV(sincV),
    .video(video),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clkP = ~clkP;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic       sh;
    logic       sv;
    logic       vid;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: linear raster index of the next coordinate, and the coordinate shown last clk.
  int         cnt = 0;
  int         lastShown = -1;
  logic [7:0] fcM = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic ce);
    exp_t e;
    int   x;
    int   y;
    logic chg;
    rst    = r;
    pix_ce = ce;
    if (r) begin
      e.x = 5'd0; e.y = 4'd0; e.sh = 1'b1; e.sv = 1'b1; e.vid = 1'b0;
      e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
      cnt = 0; lastShown = -1; fcM = 8'd0;
    end else begin
      x     = cnt % 16;
      y     = cnt / 16;
      chg   = (lastShown != -1) && (lastShown != cnt);
      e.x   = 5'(x);
      e.y   = 4'(y);
      e.vid = (x < 8) && (y < 4);
      e.sh  = !(x >= 10 && x <= 12);
      e.sv  = !(y >= 5 && y <= 6);
      e.ls  = chg && (x == 0);
      e.fs  = chg && (cnt == 0);
      if (e.fs) fcM = fcM + 8'd1;
      e.fc  = fcM;
      lastShown = cnt;
      if (ce) cnt = (cnt + 1) % 128;
    end
    sb.push_back(e);
    @(posedge clkP);
    #1;
    e = sb.pop_front();
    chk("pixelX", 32'(pixelX), 32'(e.x));
    chk("pixelY", 32'(pixelY), 32'(e.y));
    chk("sincH", 32'(sincH), 32'(e.sh));
    chk("sincV", 32'(sincV), 32'(e.sv));
    chk("video", 32'(video), 32'(e.vid));
    chk("line_start", 32'(line_start), 32'(e.ls));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
`ifdef VGA_TIMING_FRAMECNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
`endif
  endtask

  initial begin
    // Reset, including one reset clk with pix_ce low.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Continuous scan past the first frame wrap.
    for (int i = 0; i < 140; i++) step(1'b0, 1'b1);

    // Slow pixel enable across another frame wrap.
    for (int i = 0; i < 540; i++) step(1'b0, (i % 4) == 0);

    // Run until (6,2) is shown, then pulse reset for one clk.
    for (int i = 0; i < 200 && lastShown != 38; i++) step(1'b0, 1'b1);
    chk("reached_6_2", 32'(lastShown), 32'd38);
    step(1'b1, 1'b1);
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1);

    // Reset while pix_ce is held low.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

`ifdef VGA_TIMING_FRAMECNT_EN
    // Frame counter wrap after 257 frames, then cleared by reset.
    step(1'b1, 1'b1);
    for (int i = 0; i < 257 * 128 + 2; i++) step(1'b0, 1'b1);
    chk("frame_cnt_257", 32'(frame_cnt), 32'd1);
    step(1'b1, 1'b1);
    chk("frame_cnt_rst", 32'(frame_cnt), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
